// File: rtl/link_slave_fifo_if.sv
// Link slave bundle: four-phase req/ack link from the master plus the
// valid/ready consumer port. Parity signals exist only with LINK_PARITY_EN.
interface link_slave_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic [DATA_W-1:0] last_word;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CW-1:0]     count;
`ifdef LINK_PARITY_EN
  logic              parity_in;
  logic [7:0]        err_cnt;
`endif

`ifdef LINK_PARITY_EN
  modport master (output req, data_in, out_ready, parity_in,
                  input  ack, last_word, out_valid, out_data, count, err_cnt);
  modport slave  (input  req, data_in, out_ready, parity_in,
                  output ack, last_word, out_valid, out_data, count, err_cnt);
`else
  modport master (output req, data_in, out_ready,
                  input  ack, last_word, out_valid, out_data, count);
  modport slave  (input  req, data_in, out_ready,
                  output ack, last_word, out_valid, out_data, count);
`endif
endinterface

// File: rtl/link_slave_fifo.sv
// Receive end of the four-phase req/ack link. Accepted words go into a
// DEPTH-entry FIFO drained over a valid/ready port; ack is stretched for
// ACK_CYCLES cycles and withheld while the FIFO is full.
// Optional feature macro: LINK_PARITY_EN (even-parity check + error counter).
module link_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int ACK_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  link_slave_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t            state, state_nxt;
  logic [3:0]        ack_cnt, ack_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] last_word_q;
  logic              full, empty, capture, push, pop, word_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // full is taken from the pre-edge pointers, so a same-edge pop never frees a slot early
  assign capture = (state == IDLE) && bus.req && !full;
  assign push    = capture && word_ok;
  assign pop     = !empty && bus.out_ready;

`ifdef LINK_PARITY_EN
  logic [7:0] err_q;
  assign word_ok = ~(^{bus.data_in, bus.parity_in});

  // Count rejected words, saturating at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           err_q <= '0;
    else if (capture && !word_ok && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign bus.err_cnt = err_q;
`else
  assign word_ok = 1'b1;
`endif

  // Handshake state register and ack stretch counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ack_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ack_cnt <= ack_cnt_nxt;
    end
  end

  // Next-state: capture in IDLE, hold ack for ACK_CYCLES, then wait for req low
  always_comb begin
    state_nxt   = state;
    ack_cnt_nxt = ack_cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt   = ACK;
          ack_cnt_nxt = 4'(ACK_CYCLES - 1);
        end
      end
      ACK: begin
        if (ack_cnt == '0) state_nxt = WAIT_LOW;
        else               ack_cnt_nxt = ack_cnt - 4'd1;
      end
      WAIT_LOW: begin
        if (!bus.req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack = (state == ACK);

  // FIFO pointers with wrap bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are don't-care while out_valid is low
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.data_in;
  end

  // Most recently accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_word_q <= '0;
    else if (push) last_word_q <= bus.data_in;
  end

  assign bus.last_word = last_word_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.count     = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_link_slave_fifo.sv
// Bench for link_slave_fifo: table-driven handshake vectors, hand-written
// back-pressure / wrap / reset sequences, and a randomized master checked
// against a queue-based reference model. Parity checks with LINK_PARITY_EN.
module tb_link_slave_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 4;
  localparam int ACK_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  logic par_drive;
  int   errors = 0;
  int   checks = 0;

  link_slave_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
`ifdef LINK_PARITY_EN
  assign bus.parity_in = par_drive;
`endif

  link_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_CYCLES(ACK_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: words held in a queue, transfer engagement by cycle arithmetic
  logic [7:0] mq[$];
  logic [7:0] m_last;
  int         m_err;
  bit         engaged;
  int         cyc, cap_cyc;
  logic [7:0] popped[$];
  int         max_count;

  function automatic void model_reset();
    mq.delete();
    m_last  = '0;
    m_err   = 0;
    engaged = 0;
  endfunction

  function automatic void model_edge();
    bit full, popv, cap, ok;
    cyc++;
    full = (mq.size() == DEPTH);
    popv = (mq.size() != 0) && bus.out_ready;
    cap  = !engaged && bus.req && !full;
    if (engaged && (cyc - cap_cyc) > ACK_CYCLES && !bus.req) engaged = 0;
    if (popv) void'(mq.pop_front());
    if (cap) begin
      engaged = 1;
      cap_cyc = cyc;
`ifdef LINK_PARITY_EN
      ok = ((^{bus.data_in, par_drive}) == 1'b0);
`else
      ok = 1;
`endif
      if (ok) begin
        mq.push_back(bus.data_in);
        m_last = bus.data_in;
      end else if (m_err < 255) m_err++;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: record pops, advance model at the edge, compare #1 later
  task automatic step();
    if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    if (int'(bus.count) > max_count) max_count = int'(bus.count);
    check("m_ack",   32'(bus.ack),       32'(engaged && (cyc - cap_cyc) < ACK_CYCLES));
    check("m_count", 32'(bus.count),     32'(mq.size()));
    check("m_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("m_data",  32'(bus.out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check("m_last",  32'(bus.last_word), 32'(m_last));
`ifdef LINK_PARITY_EN
    check("m_err",   32'(bus.err_cnt),   32'(m_err));
`endif
  endtask

  task automatic finish_hs();
    int unsigned n = 0;
    while (!bus.ack && n < 30) begin step(); n++; end
    check("ack_seen", 32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    n = 0;
    while (bus.ack && n < 30) begin step(); n++; end
    check("ack_drop", 32'(bus.ack), 32'd0);
    step();
  endtask

  task automatic send_word(input logic [7:0] d, input logic bad);
    bus.req     = 1'b1;
    bus.data_in = d;
    par_drive   = (^d) ^ bad;
    finish_hs();
  endtask

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       ack;
    int         count;
    logic       valid;
    logic [7:0] odata;
    logic [7:0] last;
  } vec_t;

  function automatic vec_t v(logic rq, logic [7:0] d, logic rd, logic a, int c,
                             logic vl, logic [7:0] od, logic [7:0] l);
    vec_t r;
    r.req = rq; r.data = d; r.rdy = rd; r.ack = a;
    r.count = c; r.valid = vl; r.odata = od; r.last = l;
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    int unsigned idle_cycles;
    bit          saw_ack;

    // single transfer + long hold, then minimum-period pair and drain
    vt.push_back(v(1, 8'hA5, 0, 1, 1, 1, 8'hA5, 8'hA5));
    vt.push_back(v(1, 8'hA5, 0, 1, 1, 1, 8'hA5, 8'hA5));
    vt.push_back(v(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 8'hA5));
    for (int unsigned i = 0; i < 10; i++) vt.push_back(v(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 8'hA5));
    vt.push_back(v(0, 8'hA5, 0, 0, 1, 1, 8'hA5, 8'hA5));
    vt.push_back(v(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'hA5));
    vt.push_back(v(1, 8'h3C, 0, 1, 1, 1, 8'h3C, 8'h3C));
    vt.push_back(v(1, 8'h3C, 0, 1, 1, 1, 8'h3C, 8'h3C));
    vt.push_back(v(0, 8'h3C, 0, 0, 1, 1, 8'h3C, 8'h3C));
    vt.push_back(v(0, 8'h00, 0, 0, 1, 1, 8'h3C, 8'h3C));
    vt.push_back(v(1, 8'h5A, 0, 1, 2, 1, 8'h3C, 8'h5A));
    vt.push_back(v(1, 8'h5A, 0, 1, 2, 1, 8'h3C, 8'h5A));
    vt.push_back(v(0, 8'h5A, 0, 0, 2, 1, 8'h3C, 8'h5A));
    vt.push_back(v(0, 8'h00, 1, 0, 1, 1, 8'h5A, 8'h5A));
    vt.push_back(v(0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h5A));

    cyc = 0; cap_cyc = 0; max_count = 0;
    model_reset();
    rst = 1'b0; bus.req = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0; par_drive = 1'b0;
    step(); step();
    check("rst_ack",   32'(bus.ack),       32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_last",  32'(bus.last_word), 32'd0);
`ifdef LINK_PARITY_EN
    check("rst_err",   32'(bus.err_cnt),   32'd0);
`endif
    rst = 1'b1;

    foreach (vt[i]) begin
      bus.req = vt[i].req; bus.data_in = vt[i].data; bus.out_ready = vt[i].rdy;
      par_drive = ^vt[i].data;
      step();
      check("tv_ack",   32'(bus.ack),       32'(vt[i].ack));
      check("tv_count", 32'(bus.count),     32'(vt[i].count));
      check("tv_valid", 32'(bus.out_valid), 32'(vt[i].valid));
      check("tv_data",  32'(bus.out_data),  32'(vt[i].odata));
      check("tv_last",  32'(bus.last_word), 32'(vt[i].last));
    end

    // back-pressure: four words fill the FIFO, fifth waits for a pop
    bus.out_ready = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
    check("bp_full", 32'(bus.count), 32'd4);
    bus.req = 1'b1; bus.data_in = 8'h05; par_drive = ^8'h05;
    for (int unsigned k = 0; k < 6; k++) begin
      step();
      check("bp_noack", 32'(bus.ack), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_pop_noack", 32'(bus.ack),   32'd0);
    check("bp_pop_count", 32'(bus.count), 32'd3);
    bus.out_ready = 1'b0;
    step();
    check("bp_cap_ack",   32'(bus.ack),   32'd1);
    check("bp_cap_count", 32'(bus.count), 32'd4);
    finish_hs();
    bus.out_ready = 1'b1;
    for (int unsigned k = 2; k <= 5; k++) begin
      check("bp_drain", 32'(bus.out_data), 32'(k));
      step();
    end
    check("bp_empty", 32'(bus.count), 32'd0);

    // streaming through a one-deep occupancy, pointers wrap several times
    popped.delete();
    max_count = 0;
    for (int unsigned k = 0; k < 20; k++) send_word(8'(k * 7 + 3), 1'b0);
    step();
    check("wr_npop", 32'(popped.size()), 32'd20);
    for (int unsigned k = 0; k < 20; k++)
      if (k < popped.size()) check("wr_order", 32'(popped[k]), 32'(k * 7 + 3));
    check("wr_maxcnt", 32'(max_count <= 1), 32'd1);

    // asynchronous reset in the middle of an ack with two words buffered
    bus.out_ready = 1'b0;
    send_word(8'h11, 1'b0);
    bus.req = 1'b1; bus.data_in = 8'h22; par_drive = ^8'h22;
    step();
    check("mr_pre_ack",   32'(bus.ack),   32'd1);
    check("mr_pre_count", 32'(bus.count), 32'd2);
    #2 rst = 1'b0;
    #1 model_reset();
    check("mr_ack",   32'(bus.ack),       32'd0);
    check("mr_count", 32'(bus.count),     32'd0);
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_last",  32'(bus.last_word), 32'd0);
    check("mr_data",  32'(bus.out_data),  32'd0);
    step(); step();
    rst = 1'b1;
    step();
    check("mr_recap_count", 32'(bus.count),     32'd1);
    check("mr_recap_last",  32'(bus.last_word), 32'h22);
    finish_hs();
    bus.out_ready = 1'b1;
    step(); step();
    bus.out_ready = 1'b0;

`ifdef LINK_PARITY_EN
    // bad parity: acked but dropped; good parity: pushed
    send_word(8'h03, 1'b1);
    check("par_err",   32'(bus.err_cnt), 32'd1);
    check("par_drop",  32'(bus.count),   32'd0);
    send_word(8'h03, 1'b0);
    check("par_push",  32'(bus.count),     32'd1);
    check("par_last",  32'(bus.last_word), 32'h03);
    check("par_err2",  32'(bus.err_cnt),   32'd1);
    bus.out_ready = 1'b1;
    step();
`endif

    // randomized master and consumer against the model
    idle_cycles = 2;
    saw_ack = 0;
    bus.req = 1'b0;
    for (int unsigned n = 0; n < 600; n++) begin
      if (bus.ack) saw_ack = 1;
      if (!bus.req) begin
        if (!bus.ack) idle_cycles++;
        if (idle_cycles >= 2 && $urandom_range(0, 2) == 0) begin
          bus.req = 1'b1;
          bus.data_in = 8'($urandom);
          par_drive = (^bus.data_in) ^ ($urandom_range(0, 5) == 0);
          saw_ack = 0;
          idle_cycles = 0;
        end
      end else if (saw_ack && $urandom_range(0, 1) == 0) begin
        bus.req = 1'b0;
        saw_ack = 0;
        idle_cycles = 0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/link_slave_fifo.md
# link_slave_fifo

Parametrised receive end of the four-phase req/ack point-to-point link. It latches DATA_W-bit words from a master into a DEPTH-entry FIFO and stretches ack for a configurable number of cycles. It exerts back-pressure by withholding ack while the FIFO is full, and hands words to the local consumer over a valid/ready port. It is the successor to the fixed 8-bit, two-cycle-ack, unbuffered slave.

## Interface
Parameters:
- DATA_W, 8, link and FIFO word width (1..32)
- DEPTH, 4, FIFO entries; power of two, 2..64
- ACK_CYCLES, 2, cycles ack is held high per transfer (1..15)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); all state cleared while low
- req  in  1  master request, level, four-phase
- data_in  in  DATA_W  word; stable while req high
- ack  out  1  acknowledge to master
- last_word  out  DATA_W  most recently accepted word
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_W  FIFO head; 0 when out_valid low
- out_ready  in  1  consumer accepts head when high with out_valid
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- parity_in  in  1  even-parity bit (present only with LINK_PARITY_EN)
- err_cnt  out  8  parity-error count (present only with LINK_PARITY_EN)

## Operation
- FSM states: IDLE, ACK, WAIT_LOW. Reset → IDLE.
- IDLE: if req=1 and count<DEPTH at a rising edge, capture data_in into FIFO and last_word, load ack counter with ACK_CYCLES-1, go to ACK. If req=1 and FIFO is full, remain IDLE with ack=0 (back-pressure); no capture.
- ACK: ack=1 (Moore, decoded from state). The counter decrements each edge; at 0 → WAIT_LOW.
- WAIT_LOW: ack=0; go to IDLE at the first edge with req=0. A req held high never causes a second capture.
- FIFO: wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits with an extra wrap bit. Full means pointers differ only in MSB; empty means they are equal. Pointers wrap modulo 2·DEPTH.
- Pop when out_valid & out_ready at an edge. Full is evaluated before the same-edge pop, so a full FIFO with a concurrent pop still refuses capture that edge; capture occurs on the next edge.
- Push and pop on the same edge (not full, not empty): count is unchanged, both pointers advance.
- Overflow and underflow are impossible by construction. out_ready while empty is ignored.
- Reset mid-transfer: FSM → IDLE and ack drops immediately (async). FIFO is emptied. A master still holding req high after reset release is treated as a new request.

## Timing
- Reset values: ack=0, last_word=0, out_valid=0, out_data=0, count=0, err_cnt=0.
- Capture edge N (req seen high in IDLE) → ack high in cycles N+1 .. N+ACK_CYCLES → low from N+ACK_CYCLES+1.
- Minimum transfer period with immediate req drop after ack: ACK_CYCLES+2 cycles.
- Capture to out_valid: 1 cycle (out_valid high after edge N if FIFO was empty). No data bypass around the FIFO.
- last_word and count update at the capture edge.

## Configuration
- LINK_PARITY_EN defined:
  - Adds parity_in and err_cnt.
  - At capture, check that the XOR of data_in and parity_in equals 0.
  - On mismatch: the word is not pushed, last_word is not updated, err_cnt increments (saturates at 255), and the handshake still completes with a normal ack.
- LINK_PARITY_EN undefined: parity ports and logic are absent; every accepted word is pushed.

## Test plan
- Reset, then single transfer, DATA_W=8, data_in=0xA5, ACK_CYCLES=2 → ack high exactly 2 cycles starting 1 cycle after capture; last_word=0xA5; out_valid=1; out_data=0xA5; count=1.
- Master holds req high 10 cycles after ack → exactly one capture; count stays 1; FSM remains WAIT_LOW until req=0.
- DEPTH=4, out_ready=0, send 0x01..0x05 → first four acked; fifth req sees ack=0 indefinitely. Pulse out_ready one cycle → 0x01 popped, fifth word captured on the following edge, count=4. Drain order is 0x02, 0x03, 0x04, 0x05.
- Continuous push/pop with out_ready=1 over 20 words → pointers wrap; data order preserved; count never exceeds 1.
- Assert rst low mid-ACK, with 2 words buffered → ack=0 and count=0 immediately; out_valid=0; last_word=0.
- LINK_PARITY_EN: send 0x03 with parity_in=1 → acked, not pushed, err_cnt=1. Then send 0x03 with parity_in=0 → pushed.
